// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU instructions until both operands are
// available, snoops the CDB(s) for wake-up, and dispatches the lowest-index
// ready entry to the ALU through registered outputs each cycle.
// Optional feature macro: RS_LSB_CDB_EN adds the LSB CDB as a second snoop source.
`ifndef ROBENTRY
`define ROBENTRY 3:0
`endif

module reservation_station #(
  parameter int RS_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_sgn,
  input  logic [5:0]       issue_opcode,
  input  logic [31:0]      issue_Vj,
  input  logic [31:0]      issue_Vk,
  input  logic             issue_Qj_busy,
  input  logic             issue_Qk_busy,
  input  logic [`ROBENTRY] issue_Qj,
  input  logic [`ROBENTRY] issue_Qk,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [`ROBENTRY] issue_ROB_entry,
  input  logic             alu_CDB_sgn,
  input  logic [`ROBENTRY] alu_CDB_ROB_name,
  input  logic [31:0]      alu_result,
`ifdef RS_LSB_CDB_EN
  input  logic             lsb_CDB_sgn,
  input  logic [`ROBENTRY] lsb_CDB_ROB_name,
  input  logic [31:0]      lsb_result,
`endif
  output logic             RS_full,
  output logic             RS_sgn,
  output logic [5:0]       RS_opcode,
  output logic [31:0]      lhs,
  output logic [31:0]      rhs,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [`ROBENTRY] ROB_entry
);

  localparam int unsigned N     = RS_SIZE;
  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             busy;
    logic [5:0]       opcode;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_busy;
    logic             qk_busy;
    logic [`ROBENTRY] qj;
    logic [`ROBENTRY] qk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [`ROBENTRY] rob;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];

  logic             sgn_q,    sgn_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [31:0]      lhs_q,    lhs_d;
  logic [31:0]      rhs_q,    rhs_d;
  logic [31:0]      imm_q,    imm_d;
  logic [31:0]      pc_q,     pc_d;
  logic [`ROBENTRY] rob_q,    rob_d;

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   disp_idx;
  logic               disp_found;

  // Second snoop source; tied off when the LSB CDB is not present.
  logic             cdb1_v;
  logic [`ROBENTRY] cdb1_tag;
  logic [31:0]      cdb1_res;
`ifdef RS_LSB_CDB_EN
  assign cdb1_v   = lsb_CDB_sgn;
  assign cdb1_tag = lsb_CDB_ROB_name;
  assign cdb1_res = lsb_result;
`else
  assign cdb1_v   = 1'b0;
  assign cdb1_tag = '0;
  assign cdb1_res = '0;
`endif

  // Returns {still_pending, value} for an operand after snooping both CDBs.
  function automatic logic [32:0] snoop(
    input logic             pend,
    input logic [`ROBENTRY] tag,
    input logic [31:0]      val,
    input logic             a_v,
    input logic [`ROBENTRY] a_tag,
    input logic [31:0]      a_res,
    input logic             b_v,
    input logic [`ROBENTRY] b_tag,
    input logic [31:0]      b_res
  );
    if (pend && a_v && (a_tag == tag))      return {1'b0, a_res};
    else if (pend && b_v && (b_tag == tag)) return {1'b0, b_res};
    else                                    return {pend, val};
  endfunction

  // Occupancy/readiness vectors and priority pick of free slot and dispatch slot.
  always_comb begin
    busy_vec   = '0;
    ready_vec  = '0;
    free_idx   = '0;
    disp_idx   = '0;
    disp_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
    // Scan from the top so the lowest index is the last assignment to win.
    for (int unsigned i = 0; i < N; i++) begin
      if (!busy_vec[N-1-i]) free_idx = IDX_W'(N-1-i);
      if (ready_vec[N-1-i]) begin
        disp_idx   = IDX_W'(N-1-i);
        disp_found = 1'b1;
      end
    end
  end

  assign RS_full = &busy_vec;

  // Next-state: wake-up, dispatch, insert (with forwarding), then flush override.
  always_comb begin
    logic [32:0] sj;
    logic [32:0] sk;
    ent_d    = ent_q;
    sgn_d    = 1'b0;
    opcode_d = '0;
    lhs_d    = '0;
    rhs_d    = '0;
    imm_d    = '0;
    pc_d     = '0;
    rob_d    = '0;
    sj       = '0;
    sk       = '0;

    for (int unsigned i = 0; i < N; i++) begin
      if (ent_q[i].busy) begin
        sj = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj, alu_CDB_sgn,
                   alu_CDB_ROB_name, alu_result, cdb1_v, cdb1_tag, cdb1_res);
        sk = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk, alu_CDB_sgn,
                   alu_CDB_ROB_name, alu_result, cdb1_v, cdb1_tag, cdb1_res);
        ent_d[i].qj_busy = sj[32];
        ent_d[i].vj      = sj[31:0];
        ent_d[i].qk_busy = sk[32];
        ent_d[i].vk      = sk[31:0];
      end
    end

    // Dispatch reads registered operands only, so a same-edge wake-up waits a cycle.
    if (disp_found) begin
      sgn_d                 = 1'b1;
      opcode_d              = ent_q[disp_idx].opcode;
      lhs_d                 = ent_q[disp_idx].vj;
      rhs_d                 = ent_q[disp_idx].vk;
      imm_d                 = ent_q[disp_idx].imm;
      pc_d                  = ent_q[disp_idx].pc;
      rob_d                 = ent_q[disp_idx].rob;
      ent_d[disp_idx].busy  = 1'b0;
    end

    // The free slot is taken from registered busy bits, never the dispatching entry.
    if (issue_sgn && !RS_full) begin
      sj = snoop(issue_Qj_busy, issue_Qj, issue_Vj, alu_CDB_sgn,
                 alu_CDB_ROB_name, alu_result, cdb1_v, cdb1_tag, cdb1_res);
      sk = snoop(issue_Qk_busy, issue_Qk, issue_Vk, alu_CDB_sgn,
                 alu_CDB_ROB_name, alu_result, cdb1_v, cdb1_tag, cdb1_res);
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].opcode  = issue_opcode;
      ent_d[free_idx].qj_busy = sj[32];
      ent_d[free_idx].vj      = sj[31:0];
      ent_d[free_idx].qk_busy = sk[32];
      ent_d[free_idx].vk      = sk[31:0];
      ent_d[free_idx].qj      = issue_Qj;
      ent_d[free_idx].qk      = issue_Qk;
      ent_d[free_idx].imm     = issue_imm;
      ent_d[free_idx].pc      = issue_pc;
      ent_d[free_idx].rob     = issue_ROB_entry;
    end

    if (flush) begin
      for (int unsigned i = 0; i < N; i++) ent_d[i].busy = 1'b0;
      sgn_d    = 1'b0;
      opcode_d = '0;
      lhs_d    = '0;
      rhs_d    = '0;
      imm_d    = '0;
      pc_d     = '0;
      rob_d    = '0;
    end
  end

  // State register: reset wins, rdy low holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) ent_q[i] <= '0;
      sgn_q    <= 1'b0;
      opcode_q <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rob_q    <= '0;
    end else if (rdy) begin
      ent_q    <= ent_d;
      sgn_q    <= sgn_d;
      opcode_q <= opcode_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      rob_q    <= rob_d;
    end
  end

  assign RS_sgn    = sgn_q & rdy;
  assign RS_opcode = opcode_q;
  assign lhs       = lhs_q;
  assign rhs       = rhs_q;
  assign imm       = imm_q;
  assign pc        = pc_q;
  assign ROB_entry = rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (default build).
`ifndef ROBENTRY
`define ROBENTRY 3:0
`endif

module tb_reservation_station;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             issue_sgn;
  logic [5:0]       issue_opcode;
  logic [31:0]      issue_Vj, issue_Vk;
  logic             issue_Qj_busy, issue_Qk_busy;
  logic [`ROBENTRY] issue_Qj, issue_Qk;
  logic [31:0]      issue_imm, issue_pc;
  logic [`ROBENTRY] issue_ROB_entry;
  logic             alu_CDB_sgn;
  logic [`ROBENTRY] alu_CDB_ROB_name;
  logic [31:0]      alu_result;
`ifdef RS_LSB_CDB_EN
  logic             lsb_CDB_sgn;
  logic [`ROBENTRY] lsb_CDB_ROB_name;
  logic [31:0]      lsb_result;
`endif
  logic             RS_full, RS_sgn;
  logic [5:0]       RS_opcode;
  logic [31:0]      lhs, rhs, imm, pc;
  logic [`ROBENTRY] ROB_entry;

  int n_cmp = 0;
  int n_err = 0;

  reservation_station #(.RS_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_sgn(issue_sgn), .issue_opcode(issue_opcode),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_ROB_entry(issue_ROB_entry),
    .alu_CDB_sgn(alu_CDB_sgn), .alu_CDB_ROB_name(alu_CDB_ROB_name),
    .alu_result(alu_result),
`ifdef RS_LSB_CDB_EN
    .lsb_CDB_sgn(lsb_CDB_sgn), .lsb_CDB_ROB_name(lsb_CDB_ROB_name),
    .lsb_result(lsb_result),
`endif
    .RS_full(RS_full), .RS_sgn(RS_sgn), .RS_opcode(RS_opcode),
    .lhs(lhs), .rhs(rhs), .imm(imm), .pc(pc), .ROB_entry(ROB_entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_sgn        = 1'b0;
    issue_opcode     = '0;
    issue_Vj         = '0;
    issue_Vk         = '0;
    issue_Qj_busy    = 1'b0;
    issue_Qk_busy    = 1'b0;
    issue_Qj         = '0;
    issue_Qk         = '0;
    issue_imm        = '0;
    issue_pc         = '0;
    issue_ROB_entry  = '0;
    alu_CDB_sgn      = 1'b0;
    alu_CDB_ROB_name = '0;
    alu_result       = '0;
`ifdef RS_LSB_CDB_EN
    lsb_CDB_sgn      = 1'b0;
    lsb_CDB_ROB_name = '0;
    lsb_result       = '0;
`endif
  endtask

  task automatic do_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjb, input logic [3:0] qj,
                          input logic qkb, input logic [3:0] qk, input logic [3:0] tag);
    issue_sgn       = 1'b1;
    issue_opcode    = op;
    issue_Vj        = vj;
    issue_Vk        = vk;
    issue_Qj_busy   = qjb;
    issue_Qj        = qj;
    issue_Qk_busy   = qkb;
    issue_Qk        = qk;
    issue_imm       = 32'h100 + 32'(tag);
    issue_pc        = 32'h8000 + 32'(tag);
    issue_ROB_entry = tag;
  endtask

  initial begin
    idle_inputs();
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_sgn", 32'(RS_sgn), 32'd0);
    chk("rst_full", 32'(RS_full), 32'd0);
    chk("rst_lhs", lhs, 32'd0);
    chk("rst_rob", 32'(ROB_entry), 32'd0);

    // Both operands ready: dispatch registered after the following edge.
    do_issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step();
    idle_inputs();
    chk("add_not_yet", 32'(RS_sgn), 32'd0);
    step();
    chk("add_sgn", 32'(RS_sgn), 32'd1);
    chk("add_op", 32'(RS_opcode), 32'(OP_ADD));
    chk("add_lhs", lhs, 32'd5);
    chk("add_rhs", rhs, 32'd7);
    chk("add_rob", 32'(ROB_entry), 32'd3);
    chk("add_imm", imm, 32'h103);
    chk("add_pc", pc, 32'h8003);
    step();
    chk("add_done", 32'(RS_sgn), 32'd0);
    chk("add_done_lhs", lhs, 32'd0);

    // Pending Qj woken by ALU CDB two cycles after issue.
    do_issue(OP_SUB, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    step();
    idle_inputs();
    step();
    chk("sub_wait", 32'(RS_sgn), 32'd0);
    alu_CDB_sgn      = 1'b1;
    alu_CDB_ROB_name = 4'd2;
    alu_result       = 32'h10;
    step();
    idle_inputs();
    chk("sub_wake_no_disp", 32'(RS_sgn), 32'd0);
    step();
    chk("sub_sgn", 32'(RS_sgn), 32'd1);
    chk("sub_op", 32'(RS_opcode), 32'(OP_SUB));
    chk("sub_lhs", lhs, 32'h10);
    chk("sub_rhs", rhs, 32'd3);
    chk("sub_rob", 32'(ROB_entry), 32'd5);
    step();
    chk("sub_done", 32'(RS_sgn), 32'd0);

    // Insert-time forwarding of Qk from a same-cycle broadcast.
    do_issue(OP_ADD, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
    alu_CDB_sgn      = 1'b1;
    alu_CDB_ROB_name = 4'd4;
    alu_result       = 32'd9;
    step();
    idle_inputs();
    chk("fwd_not_yet", 32'(RS_sgn), 32'd0);
    step();
    chk("fwd_sgn", 32'(RS_sgn), 32'd1);
    chk("fwd_lhs", lhs, 32'd1);
    chk("fwd_rhs", rhs, 32'd9);
    chk("fwd_rob", 32'(ROB_entry), 32'd6);
    step();

    // Fill all eight entries with a pending Qj (tag i), Vk = i.
    for (int i = 0; i < 8; i++) begin
      do_issue(OP_ADD, 32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
      step();
      if (i == 6) chk("fill7_not_full", 32'(RS_full), 32'd0);
    end
    idle_inputs();
    chk("fill_full", 32'(RS_full), 32'd1);
    chk("fill_no_disp", 32'(RS_sgn), 32'd0);
    // Ninth issue, operands ready, must be dropped.
    do_issue(OP_SUB, 32'd77, 32'd88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step();
    idle_inputs();
    chk("drop_full", 32'(RS_full), 32'd1);
    step();
    chk("drop_no_disp", 32'(RS_sgn), 32'd0);
    alu_CDB_sgn      = 1'b1;
    alu_CDB_ROB_name = 4'd5;
    alu_result       = 32'h55;
    step();
    idle_inputs();
    chk("wake_still_full", 32'(RS_full), 32'd1);
    step();
    chk("wake_sgn", 32'(RS_sgn), 32'd1);
    chk("wake_rob", 32'(ROB_entry), 32'd5);
    chk("wake_lhs", lhs, 32'h55);
    chk("wake_rhs", rhs, 32'd5);
    chk("wake_not_full", 32'(RS_full), 32'd0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush1_full", 32'(RS_full), 32'd0);
    chk("flush1_sgn", 32'(RS_sgn), 32'd0);

    // Four entries waiting on tag 9, woken together, then flushed.
    for (int i = 0; i < 4; i++) begin
      do_issue(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0, 4'(i + 1));
      step();
    end
    idle_inputs();
    alu_CDB_sgn      = 1'b1;
    alu_CDB_ROB_name = 4'd9;
    alu_result       = 32'h99;
    step();
    idle_inputs();
    chk("four_ready_no_disp_yet", 32'(RS_sgn), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush2_sgn", 32'(RS_sgn), 32'd0);
    chk("flush2_full", 32'(RS_full), 32'd0);
    step();
    chk("flush2_after1", 32'(RS_sgn), 32'd0);
    step();
    chk("flush2_after2", 32'(RS_sgn), 32'd0);

    // Freeze with one ready entry; an issue during the freeze is ignored.
    do_issue(OP_ADD, 32'h20, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    step();
    idle_inputs();
    rdy = 1'b0;
    do_issue(OP_SUB, 32'h30, 32'h31, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_sgn", 32'(RS_sgn), 32'd0);
      chk("freeze_full", 32'(RS_full), 32'd0);
    end
    idle_inputs();
    rdy = 1'b1;
    step();
    chk("thaw_sgn", 32'(RS_sgn), 32'd1);
    chk("thaw_rob", 32'(ROB_entry), 32'd7);
    chk("thaw_lhs", lhs, 32'h20);
    chk("thaw_rhs", rhs, 32'h22);
    step();
    chk("thaw_no_second", 32'(RS_sgn), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
